// File: rtl/csr_router_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : csr_router_pkg
//  Purpose  : Shared types, constants and helpers for the CSR MMIO router.
//  Revision : 1.0 - initial release
// ============================================================================
package csr_router_pkg;

    // Sub-port index width; covers up to 16 sub-CSR ports.
    localparam int IDX_W = 4;

    // Widest transaction ID a pending-queue entry can carry.
    localparam int MAX_TID_W = 16;

    // Data returned for unclaimed addresses and timed-out reads.
    localparam logic [63:0] MMIO_ALL_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    // Saturation ceiling of the 16-bit status counters.
    localparam logic [15:0] STAT_MAX = 16'hFFFF;

    // One outstanding read: who asked, who answers, and how wide it is.
    typedef struct packed {
        logic [MAX_TID_W-1:0] tid;
        logic [IDX_W-1:0]     idx;
        logic                 len;
        logic                 unclaimed;
    } t_pend_entry;

    // Response engine states.
    typedef enum logic [1:0] {
        RSP_IDLE = 2'd0,
        RSP_WAIT = 2'd1,
        RSP_RESP = 2'd2
    } t_rsp_state;

    // Saturating add of a small increment (0..3) to a 16-bit counter.
    function automatic logic [15:0] sat_inc(input logic [15:0] val,
                                            input logic [1:0]  inc);
        logic [16:0] sum;
        sum = {1'b0, val} + {15'd0, inc};
        return sum[16] ? STAT_MAX : sum[15:0];
    endfunction

endpackage : csr_router_pkg
`default_nettype wire

// File: rtl/csr_router_pend_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : csr_router_pend_fifo
//  Purpose  : Synchronous FIFO with full/empty flags and simultaneous
//             push/pop; a pop on a full FIFO frees the slot for a push
//             in the same cycle.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_router_pend_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4    // power of 2, >= 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     push_ok
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] CNT_FULL = (PTR_W+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q,  count_d;
    logic             do_push,  do_pop;

    // Qualify push/pop and advance pointers and occupancy.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are meaningless while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign full      = (count_q == CNT_FULL);
    assign empty     = (count_q == '0);
    assign count     = count_q;
    assign push_ok   = do_push;

endmodule : csr_router_pend_fifo
`default_nettype wire

// File: rtl/csr_router.sv
`default_nettype none
// ============================================================================
//  Module   : csr_router
//  Purpose  : MMIO fabric decoding CCI-P MMIO requests onto NUM_SUBS CSR
//             sub-blocks through base/mask windows, with an in-order read
//             response engine, per-read timeout and unclaimed defaults.
//  Revision : 1.0 - initial release
// ============================================================================
module csr_router
    import csr_router_pkg::*;
#(
    parameter int NUM_SUBS       = 4,     // 1..16
    parameter int ADDR_WIDTH     = 16,
    parameter int TID_WIDTH      = 9,     // <= MAX_TID_W
    parameter int PEND_DEPTH     = 64,    // power of 2, >= 2
    parameter int TIMEOUT_CYCLES = 256,   // >= 4
    parameter logic [ADDR_WIDTH*NUM_SUBS-1:0] SUB_BASE = '0,
    parameter logic [ADDR_WIDTH*NUM_SUBS-1:0] SUB_MASK = '1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_is_write,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    input  logic                     req_len,
    input  logic [TID_WIDTH-1:0]     req_tid,
    input  logic [63:0]              req_wdata,
    output logic [NUM_SUBS-1:0]      sub_wr,
    output logic [NUM_SUBS-1:0]      sub_rd,
    output logic [ADDR_WIDTH-1:0]    sub_addr,
    output logic                     sub_len,
    output logic [63:0]              sub_wdata,
    input  logic [NUM_SUBS-1:0]      sub_rvalid,
    output logic [NUM_SUBS-1:0]      sub_rready,
    input  logic [64*NUM_SUBS-1:0]   sub_rdata,
    output logic [NUM_SUBS-1:0]      sub_abort,
    output logic                     rsp_valid,
    output logic [TID_WIDTH-1:0]     rsp_tid,
    output logic [63:0]              rsp_data,
    output logic [15:0]              stat_unclaimed,
    output logic [15:0]              stat_timeout,
    output logic                     stat_overflow
);

    localparam int CNT_W = $clog2(PEND_DEPTH) + 1;
    localparam int AGE_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [AGE_W-1:0] AGE_LAST = AGE_W'(TIMEOUT_CYCLES - 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic [NUM_SUBS-1:0] hit_vec;
    logic [NUM_SUBS-1:0] hit_onehot;
    logic [IDX_W-1:0]    hit_idx;
    logic                hit_any;

    for (genvar gi = 0; gi < NUM_SUBS; gi++) begin : g_decode
        assign hit_vec[gi] =
            ((req_addr & SUB_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]) ==
             (SUB_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH] & SUB_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH]));
    end

    // Priority encode: walk downwards so the lowest matching index wins.
    always_comb begin
        hit_any    = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = NUM_SUBS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_any       = 1'b1;
                hit_idx       = IDX_W'(i);
                hit_onehot    = '0;
                hit_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Pending read queue
    // ------------------------------------------------------------------
    logic              rd_req, wr_req;
    t_pend_entry       push_entry, head;
    logic              fifo_pop, fifo_push_ok, fifo_full, fifo_empty;
    logic [CNT_W-1:0]  fifo_count;

    assign rd_req = req_valid && !req_is_write;
    assign wr_req = req_valid &&  req_is_write;

    // Queue entry for an incoming read.
    always_comb begin
        push_entry           = '0;
        push_entry.tid       = MAX_TID_W'(req_tid);
        push_entry.idx       = hit_idx;
        push_entry.len       = req_len;
        push_entry.unclaimed = !hit_any;
    end

    csr_router_pend_fifo #(
        .WIDTH ($bits(t_pend_entry)),
        .DEPTH (PEND_DEPTH)
    ) u_pend_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rd_req),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .push_ok   (fifo_push_ok)
    );

    // Only the low TID_WIDTH bits of the stored tid are ever returned.
    logic tid_hi_unused;
    assign tid_hi_unused = ^head.tid;

    // ------------------------------------------------------------------
    // Dispatch stage
    // ------------------------------------------------------------------
    logic [NUM_SUBS-1:0]   sub_wr_q,    sub_wr_d;
    logic [NUM_SUBS-1:0]   sub_rd_q,    sub_rd_d;
    logic [ADDR_WIDTH-1:0] sub_addr_q,  sub_addr_d;
    logic                  sub_len_q,   sub_len_d;
    logic [63:0]           sub_wdata_q, sub_wdata_d;

    // Strobe the owning sub one cycle later; a read strobes only if queued.
    always_comb begin
        sub_wr_d    = (wr_req && hit_any) ? hit_onehot : '0;
        sub_rd_d    = (fifo_push_ok && hit_any) ? hit_onehot : '0;
        sub_addr_d  = req_valid ? req_addr  : sub_addr_q;
        sub_len_d   = req_valid ? req_len   : sub_len_q;
        sub_wdata_d = req_valid ? req_wdata : sub_wdata_q;
    end

    // ------------------------------------------------------------------
    // Response engine
    // ------------------------------------------------------------------
    t_rsp_state           state_q, state_d;
    logic [AGE_W-1:0]     age_q, age_d;
    logic                 rsp_valid_q, rsp_valid_d;
    logic [TID_WIDTH-1:0] rsp_tid_q, rsp_tid_d;
    logic [63:0]          rsp_data_q, rsp_data_d;
    logic [15:0]          stat_unclaimed_q, stat_unclaimed_d;
    logic [15:0]          stat_timeout_q, stat_timeout_d;
    logic                 stat_overflow_q, stat_overflow_d;
    logic [1:0]           unclaimed_inc;
    logic                 timeout_inc;
    logic                 rready_en, abort_en;
    logic                 rvalid_sel;
    logic [63:0]          rdata_sel;

    assign fifo_pop = (state_q == RSP_RESP);

    // Select the read channel of the sub owning the head entry.
    always_comb begin
        rvalid_sel = 1'b0;
        rdata_sel  = '0;
        for (int i = 0; i < NUM_SUBS; i++) begin
            if (head.idx == IDX_W'(i)) begin
                rvalid_sel = sub_rvalid[i];
                rdata_sel  = sub_rdata[i*64 +: 64];
            end
        end
    end

    // Next-state, response capture and counter increments.
    always_comb begin
        state_d       = state_q;
        age_d         = age_q;
        rsp_valid_d   = 1'b0;
        rsp_tid_d     = rsp_tid_q;
        rsp_data_d    = rsp_data_q;
        rready_en     = 1'b0;
        abort_en      = 1'b0;
        timeout_inc   = 1'b0;
        unclaimed_inc = {1'b0, wr_req && !hit_any};
        case (state_q)
            RSP_IDLE: begin
                if (!fifo_empty) begin
                    state_d = RSP_WAIT;
                    age_d   = '0;
                end
            end
            RSP_WAIT: begin
                age_d = age_q + 1'b1;
                if (head.unclaimed) begin
                    state_d       = RSP_RESP;
                    rsp_valid_d   = 1'b1;
                    rsp_tid_d     = head.tid[TID_WIDTH-1:0];
                    rsp_data_d    = MMIO_ALL_ONES;
                    unclaimed_inc = unclaimed_inc + 2'd1;
                end else begin
                    rready_en = 1'b1;
                    if (rvalid_sel) begin
                        // Handshake takes precedence over an expiring age.
                        state_d     = RSP_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_tid_d   = head.tid[TID_WIDTH-1:0];
                        rsp_data_d  = head.len ? rdata_sel : {32'h0, rdata_sel[31:0]};
                    end else if (age_q == AGE_LAST) begin
                        state_d     = RSP_RESP;
                        abort_en    = 1'b1;
                        timeout_inc = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_tid_d   = head.tid[TID_WIDTH-1:0];
                        rsp_data_d  = MMIO_ALL_ONES;
                    end
                end
            end
            RSP_RESP: begin
                // Head pops now; stay busy if anything remains or arrives.
                if ((fifo_count > CNT_W'(1)) || fifo_push_ok) begin
                    state_d = RSP_WAIT;
                    age_d   = '0;
                end else begin
                    state_d = RSP_IDLE;
                end
            end
            default: state_d = RSP_IDLE;
        endcase
    end

    // Status counters: saturating counts plus sticky overflow.
    always_comb begin
        stat_unclaimed_d = sat_inc(stat_unclaimed_q, unclaimed_inc);
        stat_timeout_d   = sat_inc(stat_timeout_q, {1'b0, timeout_inc});
        stat_overflow_d  = stat_overflow_q || (rd_req && fifo_full && !fifo_pop);
    end

    // Head-targeted accept and abort strobes, held low during reset.
    always_comb begin
        sub_rready = '0;
        sub_abort  = '0;
        for (int i = 0; i < NUM_SUBS; i++) begin
            sub_rready[i] = rready_en && !reset && (head.idx == IDX_W'(i));
            sub_abort[i]  = abort_en  && !reset && (head.idx == IDX_W'(i));
        end
    end

    // All router state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            sub_wr_q         <= '0;
            sub_rd_q         <= '0;
            sub_addr_q       <= '0;
            sub_len_q        <= 1'b0;
            sub_wdata_q      <= '0;
            state_q          <= RSP_IDLE;
            age_q            <= '0;
            rsp_valid_q      <= 1'b0;
            rsp_tid_q        <= '0;
            rsp_data_q       <= '0;
            stat_unclaimed_q <= '0;
            stat_timeout_q   <= '0;
            stat_overflow_q  <= 1'b0;
        end else begin
            sub_wr_q         <= sub_wr_d;
            sub_rd_q         <= sub_rd_d;
            sub_addr_q       <= sub_addr_d;
            sub_len_q        <= sub_len_d;
            sub_wdata_q      <= sub_wdata_d;
            state_q          <= state_d;
            age_q            <= age_d;
            rsp_valid_q      <= rsp_valid_d;
            rsp_tid_q        <= rsp_tid_d;
            rsp_data_q       <= rsp_data_d;
            stat_unclaimed_q <= stat_unclaimed_d;
            stat_timeout_q   <= stat_timeout_d;
            stat_overflow_q  <= stat_overflow_d;
        end
    end

    assign sub_wr         = sub_wr_q;
    assign sub_rd         = sub_rd_q;
    assign sub_addr       = sub_addr_q;
    assign sub_len        = sub_len_q;
    assign sub_wdata      = sub_wdata_q;
    assign rsp_valid      = rsp_valid_q;
    assign rsp_tid        = rsp_tid_q;
    assign rsp_data       = rsp_data_q;
    assign stat_unclaimed = stat_unclaimed_q;
    assign stat_timeout   = stat_timeout_q;
    assign stat_overflow  = stat_overflow_q;

endmodule : csr_router
`default_nettype wire
